// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: buffers one N-sample complex frame, then bursts it to the FFT input loader.
// Define FFT_FEEDER_BITREV_EN for bit-reversed burst addresses; otherwise addresses are natural order.
module fft_frame_feeder #(
  parameter int N = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [31:0]      s_real,
  input  logic signed [31:0]      s_imag,
  input  logic                    s_last,
  output logic                    new_data,
  output logic [$clog2(N)-1:0]    addr,
  output logic signed [31:0]      data_real,
  output logic signed [31:0]      data_imag,
  input  logic                    init_done,
  input  logic                    err_clr,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  localparam logic [1:0] FILL      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] BURST     = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] fill_cnt_reg, fill_cnt_next;
  logic [AW-1:0] burst_cnt_reg, burst_cnt_next;
  logic          frame_err_reg, frame_err_next;
  logic          err_set;
  logic          accept;
  logic [AW-1:0] map_addr;

  logic signed [31:0] mem_real [N];
  logic signed [31:0] mem_imag [N];

  // Gated by rst so the source never sees ready while the block is held in reset.
  assign s_ready   = (state_reg == FILL) && !rst;
  assign accept    = s_valid && s_ready;
  assign busy      = (state_reg != FILL);
  assign new_data  = (state_reg == START);
  assign frame_err = frame_err_reg;

`ifdef FFT_FEEDER_BITREV_EN
  generate
    for (genvar gi = 0; gi < AW; gi++) begin : g_rev
      assign map_addr[gi] = burst_cnt_reg[AW-1-gi];
    end
  endgenerate
`else
  assign map_addr = burst_cnt_reg;
`endif

  always_comb begin
    addr      = '0;
    data_real = '0;
    data_imag = '0;
    if (state_reg == BURST) begin
      addr      = map_addr;
      data_real = mem_real[burst_cnt_reg];
      data_imag = mem_imag[burst_cnt_reg];
    end
  end

  always_comb begin
    state_next     = state_reg;
    fill_cnt_next  = fill_cnt_reg;
    burst_cnt_next = burst_cnt_reg;
    err_set        = 1'b0;
    case (state_reg)
      FILL: begin
        if (accept) begin
          if (fill_cnt_reg == LAST_IDX) begin
            // A full frame always proceeds; a missing s_last only flags the error.
            fill_cnt_next = '0;
            state_next    = START;
            err_set       = !s_last;
          end else if (s_last) begin
            fill_cnt_next = '0;
            err_set       = 1'b1;
          end else begin
            fill_cnt_next = fill_cnt_reg + AW'(1);
          end
        end
      end
      START: begin
        burst_cnt_next = '0;
        state_next     = BURST;
      end
      BURST: begin
        burst_cnt_next = burst_cnt_reg + AW'(1);
        if (burst_cnt_reg == LAST_IDX) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (init_done) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
    frame_err_next = err_set | (frame_err_reg & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= FILL;
      fill_cnt_reg  <= '0;
      burst_cnt_reg <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fill_cnt_reg  <= fill_cnt_next;
      burst_cnt_reg <= burst_cnt_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Frame storage carries no reset; its contents are meaningless until refilled.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_real[fill_cnt_reg] <= s_real;
      mem_imag[fill_cnt_reg] <= s_imag;
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed, scoreboard-based bench for fft_frame_feeder at N=8.
// Expected burst addresses follow FFT_FEEDER_BITREV_EN the same way the design build does.
module tb_fft_frame_feeder;

  localparam int N  = 8;
  localparam int AW = $clog2(N);

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   r;
    logic [31:0]   i;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [31:0]   s_real;
  logic signed [31:0]   s_imag;
  logic                 s_last;
  logic                 new_data;
  logic [AW-1:0]        addr;
  logic signed [31:0]   data_real;
  logic signed [31:0]   data_imag;
  logic                 init_done;
  logic                 err_clr;
  logic                 frame_err;
  logic                 busy;

  int   checks   = 0;
  int   failures = 0;
  int   fill_idx = 0;
  logic exp_err  = 1'b0;
  exp_t sb_q[$];

  fft_frame_feeder #(.N(N)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
    .new_data(new_data), .addr(addr), .data_real(data_real), .data_imag(data_imag),
    .init_done(init_done), .err_clr(err_clr), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [AW-1:0] map_idx(input int k);
    logic [AW-1:0] v;
    logic [AW-1:0] r;
    v = AW'(k);
`ifdef FFT_FEEDER_BITREV_EN
    for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
`else
    r = v;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of the fill side: called for a beat that will be accepted at the next edge.
  task automatic model_accept(input logic [31:0] r, input logic [31:0] i, input logic last);
    exp_t e;
    if (fill_idx == N - 1) begin
      e.a = map_idx(fill_idx); e.r = r; e.i = i;
      sb_q.push_back(e);
      fill_idx = 0;
      if (!last) exp_err = 1'b1;
    end else if (last) begin
      sb_q.delete();
      fill_idx = 0;
      exp_err  = 1'b1;
    end else begin
      e.a = map_idx(fill_idx); e.r = r; e.i = i;
      sb_q.push_back(e);
      fill_idx++;
    end
  endtask

  task automatic send_beat(input logic [31:0] r, input logic [31:0] i, input logic last);
    int n;
    s_valid = 1'b1; s_real = r; s_imag = i; s_last = last;
    n = 0;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    check("ready_wait", {63'd0, s_ready}, 64'd1);
    model_accept(r, i, last);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Entered in the cycle after the last accepted beat (T+1).
  task automatic verify_burst(input logic glitch, input int hold);
    exp_t e;
    check("start_new_data", {63'd0, new_data}, 64'd1);
    check("start_ready", {63'd0, s_ready}, 64'd0);
    check("start_addr", {{(64-AW){1'b0}}, addr}, 64'd0);
    if (glitch) init_done = 1'b1;
    step();
    for (int k = 0; k < N; k++) begin
      s_real = $urandom; s_imag = $urandom;
      check("sb_nonempty", {63'd0, sb_q.size() != 0}, 64'd1);
      if (sb_q.size() != 0) e = sb_q.pop_front();
      else begin e.a = '0; e.r = '0; e.i = '0; end
      check($sformatf("burst_addr[%0d]", k), {{(64-AW){1'b0}}, addr}, {{(64-AW){1'b0}}, e.a});
      check($sformatf("burst_real[%0d]", k), {32'd0, data_real}, {32'd0, e.r});
      check($sformatf("burst_imag[%0d]", k), {32'd0, data_imag}, {32'd0, e.i});
      check("burst_new_data", {63'd0, new_data}, 64'd0);
      check("burst_ready", {63'd0, s_ready}, 64'd0);
      step();
    end
    init_done = 1'b0;
    for (int h = 0; h < hold; h++) begin
      check("wait_ready", {63'd0, s_ready}, 64'd0);
      check("wait_busy", {63'd0, busy}, 64'd1);
      check("wait_data", {32'd0, data_real}, 64'd0);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("done_cycle_ready", {63'd0, s_ready}, 64'd0);
    check("done_cycle_addr", {{(64-AW){1'b0}}, addr}, 64'd0);
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    check("fill_ready", {63'd0, s_ready}, 64'd1);
    check("fill_busy", {63'd0, busy}, 64'd0);
    check("frame_err", {63'd0, frame_err}, {63'd0, exp_err});
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0; s_last = 1'b0;
    init_done = 1'b0; err_clr = 1'b0;
    step();
    step();
    // Reset values.
    check("rst_ready", {63'd0, s_ready}, 64'd0);
    check("rst_new_data", {63'd0, new_data}, 64'd0);
    check("rst_addr", {{(64-AW){1'b0}}, addr}, 64'd0);
    check("rst_real", {32'd0, data_real}, 64'd0);
    check("rst_imag", {32'd0, data_imag}, 64'd0);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {63'd0, s_ready}, 64'd1);
    step();

    // Frame 1: real=k, imag=-k; init_done pulsed during START/BURST must be ignored.
    for (int k = 0; k < N; k++) send_beat(32'(k), 32'(-k), k == N - 1);
    verify_burst(1'b1, 3);

    // Short frame: s_last on 3rd beat.
    for (int k = 0; k < 3; k++) send_beat(32'(50 + k), 32'(60 + k), k == 2);
    check("short_err", {63'd0, frame_err}, 64'd1);
    check("short_new_data", {63'd0, new_data}, 64'd0);
    check("short_ready", {63'd0, s_ready}, 64'd1);
    step();
    check("short_no_start", {63'd0, new_data}, 64'd0);
    check("short_busy", {63'd0, busy}, 64'd0);
    for (int k = 0; k < N; k++) send_beat(32'(100 + k), 32'(-100 - k), k == N - 1);
    verify_burst(1'b0, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_cleared", {63'd0, frame_err}, 64'd0);

    // Set wins over a simultaneous clear.
    err_clr = 1'b1;
    send_beat(32'd7, 32'd7, 1'b1);
    err_clr = 1'b0;
    check("set_wins", {63'd0, frame_err}, 64'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_cleared2", {63'd0, frame_err}, 64'd0);

    // s_valid held high with random data; WAIT_DONE held for 20 cycles.
    s_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      s_real = $urandom; s_imag = $urandom; s_last = (k == N - 1);
      check("stream_ready", {63'd0, s_ready}, 64'd1);
      model_accept(s_real, s_imag, s_last);
      step();
    end
    s_last = 1'b0;
    verify_burst(1'b0, 20);

    // Reset in the middle of BURST at burst_cnt=3.
    for (int k = 0; k < N; k++) send_beat(32'(300 + k), 32'(-300 - k), k == N - 1);
    check("mid_new_data", {63'd0, new_data}, 64'd1);
    step();
    for (int k = 0; k < 3; k++) begin
      e = sb_q.pop_front();
      check("mid_addr", {{(64-AW){1'b0}}, addr}, {{(64-AW){1'b0}}, e.a});
      step();
    end
    e = sb_q.pop_front();
    check("mid_addr3", {{(64-AW){1'b0}}, addr}, {{(64-AW){1'b0}}, e.a});
    rst = 1'b1;
    #1;
    check("mid_rst_addr", {{(64-AW){1'b0}}, addr}, 64'd0);
    check("mid_rst_real", {32'd0, data_real}, 64'd0);
    check("mid_rst_ready", {63'd0, s_ready}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("mid_rel_ready", {63'd0, s_ready}, 64'd1);
    sb_q.delete();
    fill_idx = 0;
    exp_err  = 1'b0;
    for (int k = 0; k < N; k++) send_beat(32'(400 + k), 32'(-400 - k), k == N - 1);
    verify_burst(1'b0, 0);

    // Stall: s_valid toggled every other cycle.
    for (int k = 0; k < N; k++) begin
      s_valid = 1'b0;
      step();
      send_beat(32'(500 + k), 32'(-500 - k), k == N - 1);
    end
    verify_burst(1'b0, 1);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
